// File: rtl/wb_pkg.sv
// Shared types and default sizing for the write-back merge buffer.
package wb_pkg;

    localparam int unsigned WB_DEPTH    = 4;
    localparam int unsigned WB_DATA_W   = 32;
    localparam int unsigned WB_ADDR_W   = 5;
    localparam int unsigned WB_ZERO_REG = 0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_2w1r.sv
// Two-write/one-read circular queue with an occupancy count; the raw entry
// array and read pointer are exported so the owner can search pending entries.
module wb_fifo_2w1r
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned W     = WB_ADDR_W + WB_DATA_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr0_en,
    input  logic [W-1:0]                       wr0_data,
    input  logic                               wr1_en,
    input  logic [W-1:0]                       wr1_data,
    input  logic                               rd_en,
    output logic [W-1:0]                       head,
    output logic [$clog2(DEPTH)-1:0]           rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic [DEPTH-1:0][W-1:0]            entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;

    // The second write lands one slot after the first only when the first is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (wr0_en)
                entries[wr_ptr] <= wr0_data;
            if (wr1_en)
                entries[wr_ptr + PTR_W'(wr0_en)] <= wr1_data;
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/wb_merge_buffer.sv
// Write-back merge buffer: queues up to two RF writes per cycle, drains one per
// cycle. Pending-value forwarding is built only when WB_FWD_EN is defined.
module wb_merge_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_wr,
    input  logic [ADDR_W-1:0]            a_addr,
    input  logic [DATA_W-1:0]            a_data,
    input  logic                         m_wr,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_data,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow,
    input  logic [ADDR_W-1:0]            rs_addr,
    input  logic [ADDR_W-1:0]            rt_addr,
    output logic                         rs_hit,
    output logic                         rt_hit,
    output logic [DATA_W-1:0]            rs_data,
    output logic [DATA_W-1:0]            rt_data
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic                           a_valid, m_valid;
    logic                           push_a, push_m, pop, drop;
    logic [CNT_W-1:0]               count, free_slots;
    logic [PTR_W-1:0]               rd_ptr;
    logic [ENTRY_W-1:0]             head_raw;
    logic [DEPTH-1:0][ENTRY_W-1:0]  entries;
    entry_t                         a_entry, m_entry, head_e;

    assign a_valid = a_wr && (a_addr != ADDR_W'(WB_ZERO_REG));
    assign m_valid = m_wr && (m_addr != ADDR_W'(WB_ZERO_REG));
    assign a_entry = '{addr: a_addr, data: a_data};
    assign m_entry = '{addr: m_addr, data: m_data};

    assign pop        = (count != '0);
    assign free_slots = CNT_W'(DEPTH) - count + CNT_W'(pop);

    // ALU lane claims a slot first; the memory lane needs one beyond it.
    always_comb begin
        push_a = a_valid && (free_slots >= CNT_W'(1));
        push_m = m_valid && (free_slots >= (push_a ? CNT_W'(2) : CNT_W'(1)));
        drop   = (a_valid && !push_a) || (m_valid && !push_m);
    end

    wb_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (push_a),
        .wr0_data (a_entry),
        .wr1_en   (push_m),
        .wr1_data (m_entry),
        .rd_en    (pop),
        .head     (head_raw),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .entries  (entries)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    assign head_e    = head_raw;
    assign rf_we     = pop;
    assign rf_waddr  = pop ? head_e.addr : '0;
    assign rf_wdata  = pop ? head_e.data : '0;
    assign occupancy = count;
    assign stall     = (count >= CNT_W'(DEPTH - 1));

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        entry_t slot;
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_data = '0;
        rt_data = '0;
        slot    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = entries[rd_ptr + PTR_W'(i)];
            if (CNT_W'(i) < count) begin
                if (rs_addr != ADDR_W'(WB_ZERO_REG) && slot.addr == rs_addr) begin
                    rs_hit  = 1'b1;
                    rs_data = slot.data;
                end
                if (rt_addr != ADDR_W'(WB_ZERO_REG) && slot.addr == rt_addr) begin
                    rt_hit  = 1'b1;
                    rt_data = slot.data;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, rt_addr, rd_ptr, entries};
    assign rs_hit  = 1'b0;
    assign rt_hit  = 1'b0;
    assign rs_data = '0;
    assign rt_data = '0;
`endif

endmodule

// File: tb/tb_wb_merge_buffer.sv
// Self-checking bench for wb_merge_buffer: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_wb_merge_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_wr = 1'b0, m_wr = 1'b0;
    logic [4:0]  a_addr = '0, m_addr = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] a_data = '0, m_data = '0;
    logic        rf_we, stall, overflow, rs_hit, rt_hit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rs_data, rt_data;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    wb_entry_t q[$];
    logic      exp_ovf = 1'b0;

    always #5 clk = ~clk;

    wb_merge_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
        .m_wr(m_wr), .m_addr(m_addr), .m_data(m_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .occupancy(occupancy), .overflow(overflow),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_hit(rs_hit), .rt_hit(rt_hit), .rs_data(rs_data), .rt_data(rt_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_FWD_EN
        if (ra != 5'd0)
            foreach (q[i])
                if (q[i].addr == ra) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
`endif
    endfunction

    task automatic check_outputs();
        logic        h;
        logic [31:0] d;
        chk("rf_we",     rf_we,     q.size() != 0);
        chk("rf_waddr",  rf_waddr,  q.size() != 0 ? q[0].addr : 5'd0);
        chk("rf_wdata",  rf_wdata,  q.size() != 0 ? q[0].data : 32'd0);
        chk("occupancy", occupancy, q.size());
        chk("stall",     stall,     q.size() >= DEPTH - 1);
        chk("overflow",  overflow,  exp_ovf);
        model_fwd(rs_addr, h, d);
        chk("rs_hit", rs_hit, h);
        chk("rs_data", rs_data, d);
        model_fwd(rt_addr, h, d);
        chk("rt_hit", rt_hit, h);
        chk("rt_data", rt_data, d);
    endtask

    task automatic model_req(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        wb_entry_t e;
        if (wr && addr != 5'd0) begin
            if (q.size() < DEPTH) begin
                e.addr = addr;
                e.data = data;
                q.push_back(e);
            end else
                exp_ovf = 1'b1;
        end
    endtask

    // Called at posedge+1; checks current state, then advances one edge.
    task automatic cycle(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mw, input logic [4:0] ma, input logic [31:0] md);
        wb_entry_t dummy;
        a_wr = aw; a_addr = aa; a_data = ad;
        m_wr = mw; m_addr = ma; m_data = md;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        if (q.size() != 0) dummy = q.pop_front();
        model_req(aw, aa, ad);
        model_req(mw, ma, md);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_we"},    rf_we,     1'b0);
        chk({tag, "_rf_waddr"}, rf_waddr,  5'd0);
        chk({tag, "_rf_wdata"}, rf_wdata,  32'd0);
        chk({tag, "_stall"},    stall,     1'b0);
        chk({tag, "_occ"},      occupancy, 3'd0);
        chk({tag, "_ovf"},      overflow,  1'b0);
        chk({tag, "_rs_hit"},   rs_hit,    1'b0);
        chk({tag, "_rs_data"},  rs_data,   32'd0);
        chk({tag, "_rt_hit"},   rt_hit,    1'b0);
        chk({tag, "_rt_data"},  rt_data,   32'd0);
    endtask

    initial begin
        // Reset state
        rs_addr = 5'd9; rt_addr = 5'd4;
        #3;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk("single_we", rf_we, 1'b1);
        chk("single_addr", rf_waddr, 5'd5);
        chk("single_data", rf_wdata, 32'h1234);
        idle();
        chk("single_we_after", rf_we, 1'b0);

        // Dual same-address: ALU value written first, memory value last
        cycle(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        chk("dual_first", rf_wdata, 32'hAAAA);
        idle();
        chk("dual_second", rf_wdata, 32'hBBBB);
        chk("dual_second_addr", rf_waddr, 5'd7);
        idle();
        chk("dual_done", rf_we, 1'b0);

        // Register 0 discarded
        cycle(1'b1, 5'd0, 32'h1111, 1'b1, 5'd3, 32'h3333);
        chk("r0_occ", occupancy, 3'd1);
        chk("r0_addr", rf_waddr, 5'd3);
        idle();
        chk("r0_empty", occupancy, 3'd0);

        // Forwarding: r9 <- 1 then r9 <- 2 behind a busy queue
        cycle(1'b1, 5'd9, 32'd1, 1'b1, 5'd4, 32'h44);
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd9, 32'd2);
`ifdef WB_FWD_EN
        chk("fwd_rs_hit", rs_hit, 1'b1);
        chk("fwd_rs_data", rs_data, 32'd2);
        chk("fwd_rt_data", rt_data, 32'h44);
`else
        chk("nofwd_rs_hit", rs_hit, 1'b0);
`endif
        repeat (3) idle();
        chk("fwd_gone", rs_hit, 1'b0);

        // Fill, ignoring stall
        cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1);
        cycle(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3);
        chk("fill_occ3", occupancy, 3'd3);
        chk("fill_stall", stall, 1'b1);
        cycle(1'b1, 5'd14, 32'hA4, 1'b1, 5'd15, 32'hA5);
        chk("fill_occ4", occupancy, 3'd4);
        chk("fill_no_ovf_yet", overflow, 1'b0);
        cycle(1'b1, 5'd16, 32'hA6, 1'b1, 5'd17, 32'hA7);
        chk("fill_ovf", overflow, 1'b1);
        repeat (5) idle();
        chk("fill_ovf_sticky", overflow, 1'b1);
        chk("fill_drained", occupancy, 3'd0);

        // Reset mid-drain with 3 entries
        cycle(1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'hC1);
        cycle(1'b1, 5'd22, 32'hC2, 1'b1, 5'd23, 32'hC3);
        chk("pre_reset_occ", occupancy, 3'd3);
        a_wr = 1'b0; m_wr = 1'b0;
        rs_addr = 5'd21; rt_addr = 5'd22;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        q.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            idle();
            chk("post_reset_no_we", rf_we, 1'b0);
        end

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (DEPTH + 1) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_merge_buffer.md
# wb_merge_buffer

Write-back merge buffer downstream of the two execution subpipelines (ALU lane and memory lane) of the superscalar core. It accepts up to two register-file write requests per cycle and queues them in program order. It drains them through the single register-file write port at one per cycle and raises `stall` to the issue logic before the queue can overflow. Optionally, it forwards pending (not yet written) values to the decode-stage register reads.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥ 4.
- `DATA_W`, 32, write data width.
- `ADDR_W`, 5, register address width.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_wr`  in  1  ALU lane RegWr (older instruction of the pair).
- `a_addr`  in  ADDR_W  ALU lane Rw.
- `a_data`  in  DATA_W  ALU lane busW.
- `m_wr`  in  1  memory lane RegWr (younger instruction of the pair).
- `m_addr`  in  ADDR_W  memory lane Rw.
- `m_data`  in  DATA_W  memory lane write data.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  ADDR_W  register-file write address.
- `rf_wdata`  out  DATA_W  register-file write data.
- `stall`  out  1  issue must hold; fewer than 2 free slots are guaranteed next cycle.
- `occupancy`  out  $clog2(DEPTH+1)  current entry count.
- `overflow`  out  1  sticky: a request was dropped.
- `rs_addr`, `rt_addr`  in  ADDR_W  decode read addresses (used only with forwarding).
- `rs_hit`, `rt_hit`  out  1  a pending entry matches.
- `rs_data`, `rt_data`  out  DATA_W  youngest matching pending data.

## Operation
- A request is valid when `*_wr`=1 and `*_addr`≠0. Writes to register 0 are discarded and never enqueued.
- Enqueue order within a cycle is the ALU lane first, then the memory lane. If both lanes write the same address, both entries are enqueued, so the memory lane value lands last.
- Pop: the head is written to the register file every cycle the queue is non-empty. Push and pop in the same cycle are legal.
- Free slots are counted after this cycle's pop. If a valid request finds no slot, it is dropped, `overflow` is set, and the flag holds until reset. The ALU lane is served before the memory lane, so the memory lane is the one dropped when only one slot remains.
- `stall` = (`occupancy` ≥ DEPTH−1). It is a combinational function of the registered count.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by `occupancy`, not by pointer equality.

## Timing
- Latency from request to register-file write is ≥ 1 cycle. An entry enqueued at edge N is written at edge N+1 if the queue was empty.
- `rf_we`/`rf_waddr`/`rf_wdata` come from head state only, with no combinational path from the lane inputs.
- Reset (asynchronous, any time including mid-drain):
  - queue is emptied and pending writes are lost;
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0;
  - `stall`=0, `occupancy`=0, `overflow`=0;
  - hit outputs are 0 and data outputs are 0.
- Steady state with two valid requests every cycle: `occupancy` grows by 1 per cycle until `stall` rises.

## Configuration
- `WB_FWD_EN` defined: `rs_hit`/`rt_hit` are combinational.
  - A hit requires a match against a valid queue entry, excluding address 0. The youngest match wins.
  - The entry popped this cycle still counts as a hit, because the register-file write completes at the edge.
  - Same-cycle lane inputs are not searched.
- `WB_FWD_EN` undefined: hit and data outputs are tied to 0, and the search logic is absent.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` = {addr, data};
  - default widths;
  - `WB_ZERO_REG` = 0.
- Sub-module `wb_fifo_2w1r`: a 2-write/1-read circular queue with count, exposing the entry array for the forwarding search.
- Top-level logic: request qualification, slot allocation, the overflow flag, `stall`, and forwarding.

## Test plan
- Single ALU write: `a_wr`=1, `a_addr`=5, `a_data`=0x1234 -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234; the following cycle `rf_we`=0.
- Dual same-address: `a` writes 7←0xAAAA and `m` writes 7←0xBBBB in the same cycle -> two consecutive writes, 0xAAAA then 0xBBBB.
- Register 0: `a_addr`=0, `m_addr`=3 -> only r3 is written and `occupancy` peaks at 1.
- Fill (DEPTH=4): issue dual writes every cycle, ignoring `stall` ->
  - `stall` rises when `occupancy`=3;
  - the memory-lane request is dropped, `overflow`=1 and stays set;
  - the queue drains in order.
- Forwarding (with `WB_FWD_EN`): enqueue r9←1, then r9←2 behind a busy queue, with `rs_addr`=9 -> `rs_hit`=1 and `rs_data`=2 until the last r9 entry is popped.
- Reset mid-drain with 3 entries: `rst_n` low for one cycle -> all outputs 0 immediately, and no `rf_we` after release.
